clock_divider_controller: RTL and testbench

CLOCK_DIVIDER_CONTROLLER -- requirements
Module: clock_divider_controller

---
 rtl/clock_divider_controller_pkg.sv | 5 +
 rtl/clock_divider_core.sv | 31 +++
 rtl/clock_divider_controller.sv | 63 ++++++
 tb/tb_clock_divider_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_controller_pkg.sv
// clock_divider_controller_pkg: shared FSM states and default ratio width for the clock divider
package clock_divider_controller_pkg;
    localparam int DIVISION_WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {STOPPED, RUNNING, PENDING, STOPPING} state_t;
endpackage

// File: rtl/clock_divider_core.sv
// clock_divider_core: period counter and duty-cycle compare producing the registered divided clock
module clock_divider_core
    import clock_divider_controller_pkg::*;
#(
    parameter int DIVISION_WIDTH = DIVISION_WIDTH_DEFAULT
) (
    input  logic                      input_clock,
    input  logic                      reset,
    input  logic                      run,
    input  logic [DIVISION_WIDTH-1:0] division,
    output logic                      wrap,
    output logic                      output_clock,
    output logic                      clock_enable
);
    logic [DIVISION_WIDTH-1:0] count;
    logic [DIVISION_WIDTH:0]   high_cycles;
    // High phase is ceil(N/2) cycles, so odd ratios favour the high phase
    assign high_cycles = ({1'b0, division} + (DIVISION_WIDTH+1)'(1)) >> 1;
    assign wrap        = run && count == division - DIVISION_WIDTH'(1);
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            output_clock <= 1'b0;
            clock_enable <= 1'b0;
        end else begin
            count        <= (run && !wrap) ? count + DIVISION_WIDTH'(1) : '0;
            output_clock <= run && {1'b0, count} < high_cycles;
            clock_enable <= run && count == '0;
        end
    end
endmodule

// File: rtl/clock_divider_controller.sv
// clock_divider_controller: divided-clock generator with period-aligned ratio updates and run/stop control
module clock_divider_controller
    import clock_divider_controller_pkg::*;
#(
    parameter int DIVISION_WIDTH   = DIVISION_WIDTH_DEFAULT,
    parameter int DEFAULT_DIVISION = 2
) (
    input  logic                      input_clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DIVISION_WIDTH-1:0] cfg_division,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic                      cfg_error,
    output logic                      output_clock,
    output logic                      clock_enable,
    output logic                      locked
);
    state_t                    state, state_next;
    logic [DIVISION_WIDTH-1:0] active_division, pending_division;
    logic                      transfer, accept, wrap;
    assign cfg_ready = state == STOPPED || state == RUNNING;
    assign locked    = state == RUNNING;
    assign transfer  = cfg_valid && cfg_ready;
    assign accept    = transfer && cfg_division != '0;
    // Ratio changes and stops only take effect on the wrap cycle, so no period is ever cut short
    always_comb begin
        state_next = state;
        case (state)
            STOPPED:  state_next = enable ? RUNNING : STOPPED;
            RUNNING:  state_next = accept ? PENDING : (enable ? RUNNING : STOPPING);
            PENDING:  state_next = wrap ? (enable ? RUNNING : STOPPED) : PENDING;
            STOPPING: state_next = enable ? RUNNING : (wrap ? STOPPED : STOPPING);
            default:  state_next = STOPPED;
        endcase
    end
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            state            <= STOPPED;
            active_division  <= DIVISION_WIDTH'(DEFAULT_DIVISION);
            pending_division <= '0;
            cfg_error        <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_error <= transfer && cfg_division == '0;
            if (accept && state == STOPPED)
                active_division <= cfg_division;
            if (accept && state == RUNNING)
                pending_division <= cfg_division;
            if (state == PENDING && wrap)
                active_division <= pending_division;
        end
    end
    clock_divider_core #(.DIVISION_WIDTH(DIVISION_WIDTH)) u_core (
        .input_clock (input_clock),
        .reset       (reset),
        .run         (state != STOPPED),
        .division    (active_division),
        .wrap        (wrap),
        .output_clock(output_clock),
        .clock_enable(clock_enable)
    );
endmodule

// File: tb/tb_clock_divider_controller.sv
// tb_clock_divider_controller: scenario tasks plus randomized run against a period-level reference model
module tb_clock_divider_controller;
    logic       input_clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_division = 8'd0;
    logic       cfg_ready, cfg_error, output_clock, clock_enable, locked;
    logic [4:0] got, want;
    int         checks = 0;
    int         errors = 0;
    // Model: running flag, position within current period, ratio in force, queued ratio (0 = none), stop requested
    bit         m_run, m_stop;
    int         m_pos, m_ratio, m_q;

    assign got = {output_clock, clock_enable, locked, cfg_ready, cfg_error};
    always #5 input_clock = ~input_clock;

    clock_divider_controller dut (
        .input_clock (input_clock),
        .reset       (reset),
        .enable      (enable),
        .cfg_division(cfg_division),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_error   (cfg_error),
        .output_clock(output_clock),
        .clock_enable(clock_enable),
        .locked      (locked)
    );

    function automatic bit m_locked();
        return m_run && m_q == 0 && !m_stop;
    endfunction

    function automatic bit m_ready();
        return !m_run || m_locked();
    endfunction

    task automatic model_reset();
        m_run = 0; m_stop = 0; m_pos = 0; m_ratio = 2; m_q = 0;
        want = 5'b00010;
    endtask

    task automatic tick();
        bit fire, acc, eop, lk, pd;
        @(posedge input_clock);
        fire = cfg_valid && m_ready();
        acc  = fire && cfg_division != 0;
        lk   = m_locked();
        pd   = m_run && m_q != 0;
        eop  = m_run && m_pos == m_ratio - 1;
        want[4] = m_run && m_pos < (m_ratio + 1) / 2;
        want[3] = m_run && m_pos == 0;
        want[0] = fire && cfg_division == 0;
        m_pos = (eop || !m_run) ? 0 : m_pos + 1;
        if (!m_run) begin
            if (acc) m_ratio = cfg_division;
            if (enable) m_run = 1;
        end else if (lk) begin
            if (acc) m_q = cfg_division;
            else if (!enable) m_stop = 1;
        end else if (pd) begin
            if (eop) begin
                m_ratio = m_q; m_q = 0;
                if (!enable) m_run = 0;
            end
        end else if (enable) m_stop = 0;
        else if (eop) begin m_run = 0; m_stop = 0; end
        want[2] = m_locked();
        want[1] = m_ready();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; cfg_valid = 0;
        repeat (3) @(posedge input_clock);
        #1;
        checks++; if (got !== 5'b00010) begin errors++; $display("FAIL reset_state got=%b want=00010", got); end
        reset = 0; model_reset();
        repeat (2) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL reset_idle got=%b want=%b", got, want); end
        end
    endtask

    task automatic test_default_run();
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL default_run_model cyc=%0d got=%b want=%b", i, got, want); end
            if (i >= 1) begin
                checks++;
                if ({output_clock, clock_enable, locked} !== {i[0], i[0], 1'b1}) begin
                    errors++; $display("FAIL default_run_pattern cyc=%0d got=%b want=%b", i, {output_clock, clock_enable, locked}, {i[0], i[0], 1'b1});
                end
            end
        end
    endtask

    task automatic test_set_four();
        cfg_division = 4; cfg_valid = 1;
        tick();
        cfg_valid = 0;
        checks++; if (got !== want) begin errors++; $display("FAIL set4_accept got=%b want=%b", got, want); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL set4_ready_drop got=%b want=0", cfg_ready); end
        for (int i = 0; i < 16 && !(m_locked() && m_ratio == 4); i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL set4_settle got=%b want=%b", got, want); end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL set4_timeout locked=%b want=1", locked); end
    endtask

    task automatic test_zero_cfg();
        int n;
        cfg_division = 0; cfg_valid = 1;
        tick();
        cfg_valid = 0;
        checks++; if (got !== want) begin errors++; $display("FAIL zero_model got=%b want=%b", got, want); end
        checks++; if ({cfg_error, cfg_ready, locked} !== 3'b111) begin errors++; $display("FAIL zero_pulse got=%b want=111", {cfg_error, cfg_ready, locked}); end
        tick();
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL zero_single_pulse got=%b want=0", cfg_error); end
        for (int i = 0; i < 8 && clock_enable !== 1'b1; i++) tick();
        n = 0;
        do begin
            tick(); n++;
            checks++; if (got !== want) begin errors++; $display("FAIL zero_period_model got=%b want=%b", got, want); end
        end while (clock_enable !== 1'b1 && n < 20);
        checks++; if (n != 4) begin errors++; $display("FAIL zero_ratio_kept period=%0d want=4", n); end
    endtask

    task automatic test_ratio_change();
        logic [6:0] oc_pat, ce_pat;
        oc_pat = 7'b0011011;
        ce_pat = 7'b0010010;
        for (int i = 0; i < 8 && m_pos != 1; i++) tick();
        cfg_division = 3; cfg_valid = 1;
        tick();
        cfg_valid = 0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL change_ready_drop got=%b want=0", cfg_ready); end
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL change_model cyc=%0d got=%b want=%b", i, got, want); end
            checks++;
            if ({output_clock, clock_enable} !== {oc_pat[6-i], ce_pat[6-i]}) begin
                errors++; $display("FAIL change_pattern cyc=%0d got=%b want=%b", i, {output_clock, clock_enable}, {oc_pat[6-i], ce_pat[6-i]});
            end
        end
    endtask

    task automatic test_stop();
        logic [5:0] oc_pat;
        oc_pat = 6'b110000;
        cfg_division = 5; cfg_valid = 1;
        tick();
        cfg_valid = 0;
        for (int i = 0; i < 30 && !(m_locked() && m_ratio == 5 && m_pos == 1); i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL stop_settle got=%b want=%b", got, want); end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stop_timeout locked=%b want=1", locked); end
        enable = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL stop_model cyc=%0d got=%b want=%b", i, got, want); end
            checks++; if (output_clock !== oc_pat[5-i]) begin errors++; $display("FAIL stop_no_runt cyc=%0d got=%b want=%b", i, output_clock, oc_pat[5-i]); end
        end
        checks++; if ({clock_enable, locked, cfg_ready} !== 3'b001) begin errors++; $display("FAIL stop_final got=%b want=001", {clock_enable, locked, cfg_ready}); end
    endtask

    task automatic test_reset_pending();
        enable = 1;
        for (int i = 0; i < 4 && !m_locked(); i++) tick();
        tick();
        cfg_division = 6; cfg_valid = 1;
        tick();
        cfg_valid = 0;
        tick();
        checks++; if ({locked, cfg_ready} !== 2'b00) begin errors++; $display("FAIL rstp_pending got=%b want=00", {locked, cfg_ready}); end
        #2 reset = 1;
        #1;
        checks++; if (got !== 5'b00010) begin errors++; $display("FAIL rstp_immediate got=%b want=00010", got); end
        @(posedge input_clock);
        #1 reset = 0;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL rstp_model cyc=%0d got=%b want=%b", i, got, want); end
            if (i >= 1) begin
                checks++; if (output_clock !== i[0]) begin errors++; $display("FAIL rstp_default cyc=%0d got=%b want=%b", i, output_clock, i[0]); end
            end
        end
    endtask

    task automatic test_div1();
        enable = 0;
        for (int i = 0; i < 16 && m_run; i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL div1_stop got=%b want=%b", got, want); end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL div1_stop_timeout locked=%b want=0", locked); end
        cfg_division = 1; cfg_valid = 1;
        tick();
        cfg_valid = 0; enable = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL div1_model cyc=%0d got=%b want=%b", i, got, want); end
            checks++; if ({output_clock, clock_enable} !== 2'b11) begin errors++; $display("FAIL div1_high cyc=%0d got=%b want=11", i, {output_clock, clock_enable}); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable       = $urandom_range(0, 9) != 0;
            cfg_valid    = $urandom_range(0, 5) == 0;
            cfg_division = 8'($urandom_range(0, 7));
            tick();
            checks++; if (got !== want) begin errors++; $display("FAIL random cyc=%0d got=%b want=%b", i, got, want); end
        end
        cfg_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_default_run();
        test_set_four();
        test_zero_cfg();
        test_ratio_change();
        test_stop();
        test_reset_pending();
        test_div1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
